// File: rtl/temp_poll_sched.sv
// temp_poll_sched: restarts temp_1wire periodically or on request, waits for done with timeout/retry, latches result.
// Optional TEMP_ALARM_EN adds a signed threshold alarm refreshed on every capture.
module temp_poll_sched #(
    parameter int unsigned PERIOD_CYC  = 125_000_000,
    parameter int unsigned START_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC = 100_000_000,
    parameter int unsigned RETRY_MAX   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        force_req,
    input  logic        err_clr,
    output logic        sens_rst,
    input  logic        sens_done,
    input  logic [15:0] sens_data,
    output logic [15:0] temp_out,
    output logic        temp_valid,
    output logic        busy,
    output logic        timeout_err,
    input  logic [15:0] hi_thr,
    input  logic [15:0] lo_thr,
    output logic        alarm
);
    localparam int unsigned PW = $clog2(PERIOD_CYC + 1);
    localparam int unsigned SW = $clog2(START_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, HOLD} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   period_cnt;
    logic [SW-1:0]   start_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [2:0]      attempt;
    logic            done_q;
    logic            done_edge;
    logic            start_last, wait_last, period_last;
    logic            new_meas, retry, fail;

    assign done_edge   = sens_done & ~done_q;
    assign start_last  = (start_cnt == SW'(START_CYC - 1));
    assign wait_last   = (wait_cnt == TW'(TIMEOUT_CYC - 1));
    assign period_last = (period_cnt == PW'(PERIOD_CYC - 1));

    always_comb begin
        next_state = state;
        new_meas   = 1'b0;
        retry      = 1'b0;
        fail       = 1'b0;
        case (state)
            IDLE: begin
                if (enable || force_req) begin
                    next_state = START;
                    new_meas   = 1'b1;
                end
            end
            START: begin
                if (start_last) next_state = WAIT;
            end
            WAIT: begin
                if (done_edge) begin
                    next_state = CAPTURE;
                end else if (wait_last) begin
                    if (32'(attempt) < RETRY_MAX) begin
                        next_state = START;
                        retry      = 1'b1;
                    end else begin
                        next_state = HOLD;
                        fail       = 1'b1;
                    end
                end
            end
            CAPTURE: next_state = HOLD;
            HOLD: begin
                if (force_req || (period_last && enable)) begin
                    next_state = START;
                    new_meas   = 1'b1;
                end else if (period_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            period_cnt  <= '0;
            start_cnt   <= '0;
            wait_cnt    <= '0;
            attempt     <= '0;
            done_q      <= 1'b0;
            sens_rst    <= 1'b1;
            busy        <= 1'b0;
            temp_valid  <= 1'b0;
            temp_out    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= sens_done;
            start_cnt <= (state == START && next_state == START) ? start_cnt + 1'b1 : '0;
            wait_cnt  <= (state == WAIT && next_state == WAIT) ? wait_cnt + 1'b1 : '0;
            // Period runs from the first START of a measurement; retries do not restart it.
            if (new_meas) begin
                period_cnt <= '0;
            end else if (!period_last) begin
                period_cnt <= period_cnt + 1'b1;
            end
            if (new_meas) begin
                attempt <= '0;
            end else if (retry) begin
                attempt <= attempt + 1'b1;
            end
            sens_rst   <= (next_state == IDLE) || (next_state == START) || (next_state == HOLD);
            busy       <= (next_state == START) || (next_state == WAIT);
            temp_valid <= (state == CAPTURE);
            if (state == CAPTURE) temp_out <= sens_data;
            if (fail) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef TEMP_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (state == CAPTURE) begin
            alarm <= ($signed(sens_data) > $signed(hi_thr)) || ($signed(sens_data) < $signed(lo_thr));
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^{hi_thr, lo_thr};
    assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_temp_poll_sched.sv
// Directed bench for temp_poll_sched with a behavioural temp_1wire responder.
module tb_temp_poll_sched;
    localparam int unsigned PERIOD = 2000;
    localparam int unsigned STARTC = 4;
    localparam int unsigned TMO    = 500;
    localparam int unsigned RETRY  = 2;
`ifdef TEMP_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, force_req = 1'b0, err_clr = 1'b0;
    logic        sens_done = 1'b0;
    logic [15:0] sens_data = 16'h0000, hi_thr = 16'h0190, lo_thr = 16'hFF00;
    logic        sens_rst, temp_valid, busy, timeout_err, alarm;
    logic [15:0] temp_out;
    int          checks = 0, failures = 0;
    int          cyc = 0;

    temp_poll_sched #(
        .PERIOD_CYC (PERIOD),
        .START_CYC  (STARTC),
        .TIMEOUT_CYC(TMO),
        .RETRY_MAX  (RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_req(force_req), .err_clr(err_clr),
        .sens_rst(sens_rst), .sens_done(sens_done), .sens_data(sens_data),
        .temp_out(temp_out), .temp_valid(temp_valid), .busy(busy), .timeout_err(timeout_err),
        .hi_thr(hi_thr), .lo_thr(lo_thr), .alarm(alarm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model: answers 100 cycles after sens_rst falls, once fall_cnt reaches ans_from.
    int   mcnt = 0, fall_cnt = 0, ans_from = 1 << 30;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        rst_q <= sens_rst;
        if (sens_rst) begin
            mcnt      <= 0;
            sens_done <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (rst_q) fall_cnt <= fall_cnt + 1;
            if (mcnt == 99 && fall_cnt >= ans_from) sens_done <= 1'b1;
        end
    end

    int   start_q[$], fall_q[$], done_cq[$], valid_q[$];
    logic prev_sr = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (sens_rst && busy && !(prev_sr && prev_busy)) start_q.push_back(cyc);
        if (prev_sr && !sens_rst) fall_q.push_back(cyc);
        if (sens_done && !prev_done) done_cq.push_back(cyc);
        if (temp_valid) valid_q.push_back(cyc);
        prev_sr   <= sens_rst;
        prev_busy <= busy;
        prev_done <= sens_done;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int          silent;
        logic [15:0] data;
        logic [15:0] exp_temp;
        logic        exp_err;
        logic        exp_alarm;
        int          exp_starts;
        int          exp_valids;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int sb, fb, vb, db, c, s3, nv;
        bit ok;
        vecs[0] = '{0, 16'h0191, 16'h0191, 1'b0, ALARM_ON, 1, 1};
        vecs[1] = '{0, 16'h0100, 16'h0100, 1'b0, 1'b0,     1, 1};
        vecs[2] = '{0, 16'hFE00, 16'hFE00, 1'b0, ALARM_ON, 1, 1};
        vecs[3] = '{1, 16'h00A0, 16'h00A0, 1'b0, 1'b0,     2, 1};
        vecs[4] = '{3, 16'h1234, 16'h00A0, 1'b1, 1'b0,     3, 0};

        repeat (3) tick;
        chk("rst_sens_rst", sens_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_temp_out", temp_out, 0);
        chk("rst_valid", temp_valid, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_alarm", alarm, 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) begin
            sens_data = vecs[i].data;
            ans_from  = fall_cnt + vecs[i].silent + 1;
            sb = start_q.size(); fb = fall_q.size(); vb = valid_q.size(); db = done_cq.size();
            force_req = 1'b1; c = cyc;
            tick;
            force_req = 1'b0;
            ok = 0;
            for (int k = 0; k < 3000; k++) begin
                tick;
                if (!busy) begin ok = 1; break; end
            end
            chk($sformatf("v%0d_meas_end", i), ok, 1);
            tick; tick;
            chk($sformatf("v%0d_starts", i), start_q.size() - sb, vecs[i].exp_starts);
            chk($sformatf("v%0d_start_lat", i), (start_q.size() > sb) ? start_q[sb] - c : -1, 1);
            chk($sformatf("v%0d_fall_lat", i), (fall_q.size() > fb) ? fall_q[fb] - c : -1, STARTC + 1);
            chk($sformatf("v%0d_valids", i), valid_q.size() - vb, vecs[i].exp_valids);
            if (vecs[i].exp_valids > 0)
                chk($sformatf("v%0d_done_to_valid", i),
                    (valid_q.size() > vb && done_cq.size() > db) ? valid_q[vb] - done_cq[db] : -1, 2);
            chk($sformatf("v%0d_temp_out", i), temp_out, vecs[i].exp_temp);
            chk($sformatf("v%0d_timeout_err", i), timeout_err, vecs[i].exp_err);
            chk($sformatf("v%0d_alarm", i), alarm, vecs[i].exp_alarm);
        end

        sb = start_q.size();
        repeat (2600) tick;
        chk("no_restart_disabled", start_q.size() - sb, 0);
        chk("idle_sens_rst", sens_rst, 1);

        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 0);

        // Clear asserted in the exact cycle the final timeout fires: set must win.
        ans_from = fall_cnt + 100;
        sb = start_q.size();
        force_req = 1'b1;
        tick;
        force_req = 1'b0;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (start_q.size() >= sb + 3) begin ok = 1; break; end
            tick;
        end
        chk("third_attempt_seen", ok, 1);
        s3 = ok ? start_q[sb + 2] : cyc;
        while (cyc < s3 + int'(STARTC) + int'(TMO) - 1) tick;
        chk("err_before_set", timeout_err, 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("set_wins_over_clr", timeout_err, 1);
        tick;
        chk("err_sticky", timeout_err, 1);

        sens_data = 16'h0123;
        ans_from  = fall_cnt + 1;
        enable    = 1'b1;
        sb = start_q.size();
        ok = 0;
        for (int k = 0; k < 10000; k++) begin
            if (start_q.size() >= sb + 4) begin ok = 1; break; end
            tick;
        end
        chk("periodic_starts_seen", ok, 1);
        for (int j = 0; j < 3; j++)
            chk($sformatf("period_gap%0d", j),
                (start_q.size() > sb + j + 1) ? start_q[sb + j + 1] - start_q[sb + j] : -1, PERIOD);
        nv = 0;
        if (ok) foreach (valid_q[v]) if (valid_q[v] > start_q[sb] && valid_q[v] < start_q[sb + 3]) nv++;
        chk("periodic_valids", nv, 3);
        chk("periodic_temp_out", temp_out, 16'h0123);

        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!sens_rst && busy) begin ok = 1; break; end
            tick;
        end
        chk("wait_reached", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sens_rst", sens_rst, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_temp_out", temp_out, 0);
        chk("async_rst_err", timeout_err, 0);
        chk("async_rst_valid", temp_valid, 0);
        tick;
        rst_n  = 1'b1;
        enable = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/temp_poll_sched.md
# temp_poll_sched

Periodic measurement scheduler for the `temp_1wire` temperature sensor engine. Restarts the engine at a fixed interval or on request, waits for its `done` with timeout and bounded retry, and latches the 16-bit result with a valid strobe. Sits between the board housekeeping/register logic and `temp_1wire`, owning that engine's active-high `rst` input.

## Interface
- `PERIOD_CYC`, 125_000_000: cycles from one measurement start to the next (1 s at 125 MHz); ≥ `START_CYC`+2.
- `START_CYC`, 16: width of the restart pulse on `sens_rst`, in cycles; ≥1.
- `TIMEOUT_CYC`, 100_000_000: cycles allowed in WAIT after the pulse ends before the attempt is declared failed.
- `RETRY_MAX`, 2: extra attempts after a timeout before reporting an error; 0..7.

Ports:
- `clk`  in  1  system clock, 125 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  periodic polling enable; level.
- `force_req`  in  1  one-cycle request for an immediate measurement.
- `err_clr`  in  1  one-cycle clear of `timeout_err`.
- `sens_rst`  out  1  drives `temp_1wire.rst`; high = engine held in reset and restarted on release.
- `sens_done`  in  1  `temp_1wire.done`.
- `sens_data`  in  16  `temp_1wire.temp_data`.
- `temp_out`  out  16  last good result.
- `temp_valid`  out  1  one-cycle strobe, `temp_out` updated.
- `busy`  out  1  measurement in progress (START or WAIT).
- `timeout_err`  out  1  sticky: all attempts of a measurement timed out.
- `hi_thr`, `lo_thr`  in  16 each  signed alarm thresholds (`TEMP_ALARM_EN` only).
- `alarm`  out  1  threshold alarm (`TEMP_ALARM_EN` only).

## Operation
- States: IDLE, START, WAIT, CAPTURE, HOLD.
- IDLE: `sens_rst`=1 (engine parked). Go to START when `enable`=1 or `force_req`=1.
- START: `sens_rst`=1 for `START_CYC` cycles, attempt counter loaded (first entry) with 0; then WAIT.
- WAIT: `sens_rst`=0; timeout counter runs. Rising edge of `sens_done` (registered 0->1) -> CAPTURE. Counter reaching `TIMEOUT_CYC` -> if attempts < `RETRY_MAX`, attempts+1 and back to START; else set `timeout_err`, go HOLD.
- CAPTURE (one cycle): `temp_out` <= `sens_data`, `temp_valid`=1, go HOLD.
- HOLD: `sens_rst`=1; wait for the period counter; at expiry -> START if `enable`, else IDLE. `force_req` in HOLD -> START at once.
- Period counter starts at 0 on every entry to START from IDLE/HOLD (not on retries) and saturates at `PERIOD_CYC`-1.
- `force_req` in START/WAIT/CAPTURE is ignored (not queued).
- `enable` falling mid-measurement: the current measurement completes; next decision in HOLD.
- `err_clr` clears `timeout_err`; simultaneous set and clear -> set wins.
- `sens_data` sampled only in CAPTURE; a `done` already high at WAIT entry is not an edge.

## Timing
- Reset values: state IDLE, `sens_rst`=1, `temp_out`=0, `temp_valid`=0, `busy`=0, `timeout_err`=0, `alarm`=0, all counters 0.
- `force_req` at cycle N in IDLE -> START at N+1, `sens_rst` high N+1..N+`START_CYC`, low from N+`START_CYC`+1.
- `sens_done` rising at cycle M in WAIT -> `temp_valid` and new `temp_out` at M+2 (edge register + CAPTURE).
- Timeout: WAIT lasting `TIMEOUT_CYC` cycles with no edge -> next cycle START (retry) or HOLD with `timeout_err`=1.
- `busy`=1 exactly in START and WAIT, registered.
- `rst_n` low at any time: immediate return to reset values; in-flight measurement discarded.

## Configuration
- `TEMP_ALARM_EN` defined: `alarm` updates in CAPTURE: 1 if signed `sens_data` > `hi_thr` or < `lo_thr`, else 0; held until next CAPTURE or reset.
- Not defined: `hi_thr`/`lo_thr` ignored, `alarm` constant 0, no comparator logic.

## Test plan
Bench parameters: `PERIOD_CYC`=2000, `START_CYC`=4, `TIMEOUT_CYC`=500, `RETRY_MAX`=2.
- Reset: `rst_n`=0 mid-WAIT -> same cycle `sens_rst`=1, `busy`=0, `temp_out`=0.
- Forced read: `force_req` pulse, model raises `done` 100 cycles after `sens_rst` falls with data 0x0191 -> `temp_valid` one cycle, `temp_out`=0x0191, no further start while `enable`=0.
- Periodic: `enable`=1, model answers each time -> START entries exactly 2000 cycles apart, one `temp_valid` per period.
- Retry/timeout: model never answers -> 3 restart pulses, `timeout_err`=1 after the third 500-cycle wait; `err_clr` -> 0; set+clear same cycle -> stays 1.
- Retry success: model silent on attempt 1, answers 0x00A0 on attempt 2 -> `temp_out`=0x00A0, `timeout_err`=0.
- Alarm (`TEMP_ALARM_EN`): `hi_thr`=0x0190, `lo_thr`=0xFF00; results 0x0191, 0x0100, 0xFE00 -> `alarm` 1, 0, 1; macro undefined -> always 0.
